hi_sim_bpsk_tx: RTL and testbench

//  Tag-side BPSK load-modulation transmitter for HF simulation (ISO14443B-style, fc/16 subcarrier).

---
 rtl/hi_sim_bpsk_tx_pkg.sv | 23 ++
 rtl/hi_sim_bpsk_tx_if.sv | 29 ++
 rtl/hi_sim_bpsk_tx_ssp_byte_fetch.sv | 84 ++++++++
 rtl/hi_sim_bpsk_tx.sv | 160 ++++++++++++++++
 tb/tb_hi_sim_bpsk_tx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hi_sim_bpsk_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : hi_sim_bpsk_tx_pkg
// Brief  : Shared state encoding and default divider constants for the
//          tag-side BPSK load-modulation transmitter.
// Rev    : 1.0  initial release
// ============================================================================
package hi_sim_bpsk_tx_pkg;

  // Default dividers, all in fc (13.56 MHz) cycles.
  localparam int unsigned SUB_DIV_DEF   = 16;  // subcarrier period
  localparam int unsigned SUB_PER_B_DEF = 8;   // subcarrier periods per bit
  localparam int unsigned SSP_DIV_DEF   = 16;  // ssp_clk period
  localparam int unsigned BYTE_BITS     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } tx_state_t;

endpackage : hi_sim_bpsk_tx_pkg
`default_nettype wire

// File: rtl/hi_sim_bpsk_tx_if.sv
`default_nettype none
// ============================================================================
// Module : hi_sim_bpsk_tx_if
// Brief  : Bundle of the transmitter's control, SSP and modulation signals.
//          master = transmitter (SSP clock master), slave = ARM / host side.
// Rev    : 1.0  initial release
// ============================================================================
interface hi_sim_bpsk_tx_if;
  logic enable;
  logic ssp_dout;
  logic ssp_clk;
  logic ssp_frame;
  logic ssp_din;
  logic mod_out;
  logic tx_active;
  logic underrun;
  logic dbg;

  modport master (
    input  enable, ssp_dout,
    output ssp_clk, ssp_frame, ssp_din, mod_out, tx_active, underrun, dbg
  );

  modport slave (
    output enable, ssp_dout,
    input  ssp_clk, ssp_frame, ssp_din, mod_out, tx_active, underrun, dbg
  );
endinterface : hi_sim_bpsk_tx_if
`default_nettype wire

// File: rtl/hi_sim_bpsk_tx_ssp_byte_fetch.sv
`default_nettype none
// ============================================================================
// Module : hi_sim_bpsk_tx_ssp_byte_fetch
// Brief  : Clocks one byte in from the ARM over SSP, MSB first. Eight slots
//          of SSP_DIV cycles; ssp_clk high for the first half of each slot,
//          ssp_frame high for slot 0, data sampled when ssp_clk falls.
//          done pulses on the last fetch cycle while rx_byte is complete.
// Rev    : 1.0  initial release
// ============================================================================
module hi_sim_bpsk_tx_ssp_byte_fetch
  import hi_sim_bpsk_tx_pkg::*;
#(
  parameter int unsigned SSP_DIV = SSP_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       ssp_dout,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam int unsigned SLOT_W = $clog2(SSP_DIV);
  localparam int unsigned CNT_W  = SLOT_W + 3;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BYTE_BITS * SSP_DIV - 1);
  localparam logic [SLOT_W-1:0] SAMPLE_AT = SLOT_W'(SSP_DIV / 2);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic             r_ssp_clk;
  logic             r_ssp_frame;
  logic             w_active_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next fetch position; abort beats start, start beats normal completion.
  always_comb begin
    w_active_nxt = r_active;
    w_cnt_nxt    = r_cnt;
    if (abort) begin
      w_active_nxt = 1'b0;
      w_cnt_nxt    = '0;
    end else if (start) begin
      w_active_nxt = 1'b1;
      w_cnt_nxt    = '0;
    end else if (r_active) begin
      if (r_cnt == CNT_LAST) begin
        w_active_nxt = 1'b0;
        w_cnt_nxt    = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Counter, registered SSP strobes (decoded from the next position) and data shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ssp_clk   <= 1'b0;
      r_ssp_frame <= 1'b0;
    end else begin
      r_active    <= w_active_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ssp_clk   <= w_active_nxt & ~w_cnt_nxt[SLOT_W-1];
      r_ssp_frame <= w_active_nxt & (w_cnt_nxt[CNT_W-1:SLOT_W] == 3'd0);
      if (r_active && !abort && (r_cnt[SLOT_W-1:0] == SAMPLE_AT)) begin
        r_shift <= {r_shift[6:0], ssp_dout};
      end
    end
  end

  assign ssp_clk   = r_ssp_clk;
  assign ssp_frame = r_ssp_frame;
  assign rx_byte   = r_shift;
  assign done      = r_active && (r_cnt == CNT_LAST);

endmodule : hi_sim_bpsk_tx_ssp_byte_fetch
`default_nettype wire

// File: rtl/hi_sim_bpsk_tx.sv
`default_nettype none
// ============================================================================
// Module : hi_sim_bpsk_tx
// Brief  : Tag-side BPSK load-modulation transmitter (fc/16 subcarrier).
//          Fetches bytes from the ARM over SSP and sends them LSB first as a
//          phase-modulated subcarrier on mod_out, double-buffered so bytes
//          follow each other without a gap.
// Rev    : 1.0  initial release
// ============================================================================
module hi_sim_bpsk_tx
  import hi_sim_bpsk_tx_pkg::*;
#(
  parameter int unsigned SUB_DIV   = SUB_DIV_DEF,
  parameter int unsigned SUB_PER_B = SUB_PER_B_DEF,
  parameter int unsigned SSP_DIV   = SSP_DIV_DEF
) (
  input  logic              ck_1356meg,
  input  logic              reset,
  hi_sim_bpsk_tx_if.master  bus
);

  // bit_cnt wraps on its own, so SUB_DIV*SUB_PER_B must be a power of two.
  localparam int unsigned BIT_W   = $clog2(SUB_DIV * SUB_PER_B);
  localparam int unsigned SUB_MSB = $clog2(SUB_DIV) - 1;

  tx_state_t        r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [2:0]       r_byte_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_hold;
  logic             r_hold_valid;
  logic             r_mod;
  logic             r_tx_active;
  logic             r_underrun;

  logic             w_sub;
  logic             w_bit_end;
  logic             w_byte_end;
  logic             w_fetch_start;
  logic             w_fetch_abort;
  logic             w_fetch_done;
  logic [7:0]       w_fetch_byte;
  logic             w_ssp_clk;
  logic             w_ssp_frame;

  assign w_sub      = ~r_bit_cnt[SUB_MSB];
  assign w_bit_end  = (r_state == ST_SEND) && (&r_bit_cnt);
  assign w_byte_end = w_bit_end && (r_byte_bit == 3'd7);

  // A fetch starts on the edge that enters FETCH, and on every edge that
  // starts a new byte in SEND, so the look-ahead fetch runs during bit 0.
  // Dropping enable kills any fetch in progress.
  assign w_fetch_start = bus.enable &&
                         ((r_state == ST_IDLE) ||
                          ((r_state == ST_FETCH) && w_fetch_done) ||
                          (w_byte_end && r_hold_valid));
  assign w_fetch_abort = ~bus.enable;

  hi_sim_bpsk_tx_ssp_byte_fetch #(
    .SSP_DIV (SSP_DIV)
  ) u_fetch (
    .clk       (ck_1356meg),
    .rst       (reset),
    .start     (w_fetch_start),
    .abort     (w_fetch_abort),
    .ssp_dout  (bus.ssp_dout),
    .ssp_clk   (w_ssp_clk),
    .ssp_frame (w_ssp_frame),
    .rx_byte   (w_fetch_byte),
    .done      (w_fetch_done)
  );

  // Transmit FSM with bit timing, shift/holding registers and registered outputs.
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_byte_bit   <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_mod        <= 1'b0;
      r_tx_active  <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mod     <= 1'b0;
          r_bit_cnt <= '0;
          if (bus.enable) begin
            r_state      <= ST_FETCH;
            r_tx_active  <= 1'b1;
            r_underrun   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_byte_bit   <= '0;
          end
        end

        ST_FETCH: begin
          r_mod <= 1'b0;
          if (!bus.enable) begin
            r_state     <= ST_IDLE;
            r_tx_active <= 1'b0;
          end else if (w_fetch_done) begin
            // First byte skips the holding register.
            r_state    <= ST_SEND;
            r_shift    <= w_fetch_byte;
            r_bit_cnt  <= '0;
            r_byte_bit <= '0;
          end
        end

        ST_SEND: begin
          // Bit 1 keeps the reference phase, bit 0 inverts the subcarrier.
          r_mod     <= w_sub ~^ r_shift[0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_fetch_done && bus.enable) begin
            r_hold       <= w_fetch_byte;
            r_hold_valid <= 1'b1;
          end
          if (w_byte_end) begin
            r_byte_bit <= '0;
            if (!bus.enable) begin
              // Stop request wins; any buffered byte is dropped.
              r_state      <= ST_IDLE;
              r_tx_active  <= 1'b0;
              r_hold_valid <= 1'b0;
            end else if (!r_hold_valid) begin
              r_state     <= ST_IDLE;
              r_tx_active <= 1'b0;
              r_underrun  <= 1'b1;
            end else begin
              r_shift      <= r_hold;
              r_hold_valid <= 1'b0;
            end
          end else if (w_bit_end) begin
            r_shift    <= {1'b0, r_shift[7:1]};
            r_byte_bit <= r_byte_bit + 3'd1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_tx_active <= 1'b0;
          r_mod       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ssp_clk   = w_ssp_clk;
  assign bus.ssp_frame = w_ssp_frame;
  assign bus.ssp_din   = r_underrun;
  assign bus.mod_out   = r_mod;
  assign bus.tx_active = r_tx_active;
  assign bus.underrun  = r_underrun;
  assign bus.dbg       = r_shift[0];

endmodule : hi_sim_bpsk_tx
`default_nettype wire

// File: tb/tb_hi_sim_bpsk_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_hi_sim_bpsk_tx
// Brief  : Self-checking bench for hi_sim_bpsk_tx. An ARM model serves bytes
//          on SSP; whole waveforms are logged per scenario and compared in
//          128-cycle windows against a timeline computed from the bytes sent.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hi_sim_bpsk_tx;

  localparam int LOG_LEN = 4096;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  hi_sim_bpsk_tx_if bus ();

  hi_sim_bpsk_tx u_dut (
    .ck_1356meg (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // ARM side: a new byte on every frame, one bit per ssp_clk period, MSB first.
  logic [7:0] arm_q[$];
  logic [7:0] arm_sr;
  int         arm_slot;
  logic       arm_prev_clk;

  always @(negedge clk) begin
    if (bus.ssp_clk && !arm_prev_clk) begin
      if (bus.ssp_frame) begin
        if (arm_q.size() > 0) arm_sr = arm_q.pop_front();
        else                  arm_sr = 8'($urandom);
        arm_slot = 0;
      end else begin
        arm_slot = arm_slot + 1;
      end
      bus.ssp_dout = arm_sr[7 - (arm_slot % 8)];
    end
    arm_prev_clk = bus.ssp_clk;
  end

  // Scenario description used by the reference timeline.
  logic [7:0] tx_bytes[0:3];
  int         g_nb;
  int         g_abort;
  int         g_urun;

  logic log_mod[0:LOG_LEN-1];
  logic log_act[0:LOG_LEN-1];
  logic log_frm[0:LOG_LEN-1];
  logic log_clk[0:LOG_LEN-1];
  logic log_urn[0:LOG_LEN-1];
  logic log_din[0:LOG_LEN-1];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_log(input int c);
    @(negedge clk);
    log_mod[c] = bus.mod_out;
    log_act[c] = bus.tx_active;
    log_frm[c] = bus.ssp_frame;
    log_clk[c] = bus.ssp_clk;
    log_urn[c] = bus.underrun;
    log_din[c] = bus.ssp_din;
  endtask

  // Offset inside an active SSP fetch at cycle t (enable seen at t=0), or -1.
  // First fetch: t=1..128. Look-ahead fetch i: 128 cycles from the start of byte i.
  function automatic int fetch_off(input int t);
    int s, e;
    if (t >= 1 && t <= 128) return t - 1;
    for (int i = 0; i < g_nb; i++) begin
      s = 129 + 1024 * i;
      e = s + 127;
      if (g_abort >= s && g_abort < e) e = g_abort;
      if (t >= s && t <= e) return t - s;
    end
    return -1;
  endfunction

  // Expected value of a signal at cycle t: 0 mod_out, 1 tx_active, 2 frame, 3 ssp_clk, 4 underrun.
  function automatic logic exp_sig(input int sel, input int t);
    int   k, off, len;
    logic b, sub;
    len = 1024 * g_nb;
    case (sel)
      0: begin
        if (t < 130 || t > 129 + len) return 1'b0;
        k   = t - 130;
        b   = tx_bytes[k / 1024][(k / 128) % 8];
        sub = ((k % 16) < 8);
        return (sub == b);
      end
      1: return (t >= 1 && t <= 128 + len);
      2: begin
        off = fetch_off(t);
        return (off >= 0 && off < 16);
      end
      3: begin
        off = fetch_off(t);
        return (off >= 0 && (off % 16) < 8);
      end
      default: return (g_urun >= 0 && t >= g_urun);
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_mod"},   128'(bus.mod_out),   128'd0);
    check({tag, "_sclk"},  128'(bus.ssp_clk),   128'd0);
    check({tag, "_frame"}, 128'(bus.ssp_frame), 128'd0);
    check({tag, "_act"},   128'(bus.tx_active), 128'd0);
    check({tag, "_urun"},  128'(bus.underrun),  128'd0);
    check({tag, "_din"},   128'(bus.ssp_din),   128'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    arm_q.delete();
    step();
    step();
    check_idle("rst_state");
    reset = 1'b0;
    step();
  endtask

  // Runs one transmission; enable rises in cycle 0, drops at drop_t, is
  // pulsed low for one cycle at abort_t, and dropped at urun_t.
  task automatic run_case(input string tag, input int nb, input int drop_t,
                          input int abort_t, input int urun_t);
    int total;
    logic [127:0] om, em, oa, ea, of, ef, oc, ec, ou, eu, od;
    do_reset();
    g_nb = nb; g_abort = abort_t; g_urun = urun_t;
    for (int i = 0; i < nb; i++) arm_q.push_back(tx_bytes[i]);
    arm_q.push_back(8'($urandom));
    arm_q.push_back(8'($urandom));
    total = 129 + 1024 * nb + 200;
    for (int c = 0; c < total; c++) begin
      step_log(c);
      if (c == 0)           bus.enable = 1'b1;
      if (c == drop_t)      bus.enable = 1'b0;
      if (c == abort_t)     bus.enable = 1'b0;
      if (c == abort_t + 1) bus.enable = 1'b1;
      if (c == urun_t)      bus.enable = 1'b0;
    end
    for (int w = 0; w * 128 < total; w++) begin
      om = '0; em = '0; oa = '0; ea = '0; of = '0; ef = '0;
      oc = '0; ec = '0; ou = '0; eu = '0; od = '0;
      for (int i = 0; i < 128; i++) begin
        if (w * 128 + i < total) begin
          om[i] = log_mod[w*128+i]; em[i] = exp_sig(0, w*128+i);
          oa[i] = log_act[w*128+i]; ea[i] = exp_sig(1, w*128+i);
          of[i] = log_frm[w*128+i]; ef[i] = exp_sig(2, w*128+i);
          oc[i] = log_clk[w*128+i]; ec[i] = exp_sig(3, w*128+i);
          ou[i] = log_urn[w*128+i]; eu[i] = exp_sig(4, w*128+i);
          od[i] = log_din[w*128+i];
        end
      end
      check($sformatf("%s_mod_w%0d", tag, w),   om, em);
      check($sformatf("%s_act_w%0d", tag, w),   oa, ea);
      check($sformatf("%s_frame_w%0d", tag, w), of, ef);
      check($sformatf("%s_sclk_w%0d", tag, w),  oc, ec);
      check($sformatf("%s_urun_w%0d", tag, w),  ou, eu);
      check($sformatf("%s_din_w%0d", tag, w),   od, eu);
    end
  endtask

  initial begin
    int nb, bt, off;
    clk = 1'b0; reset = 1'b1; bus.enable = 1'b0; bus.ssp_dout = 1'b0;
    arm_sr = '0; arm_slot = 0; arm_prev_clk = 1'b0;
    n_total = 0; n_bad = 0;

    // Single byte 0xA5, stopped mid-byte; latency points checked explicitly.
    tx_bytes[0] = 8'hA5;
    run_case("a5", 1, 129 + 2 * 128 + 5, -1, -1);
    check("lat_frame_n",    128'(log_frm[0]),   128'd0);
    check("lat_frame_n1",   128'(log_frm[1]),   128'd1);
    check("lat_mod_n129",   128'(log_mod[129]), 128'd0);
    check("lat_mod_n130",   128'(log_mod[130]), 128'd1);

    // 0xFF then 0x00 back to back: one phase inversion at the byte seam.
    tx_bytes[0] = 8'hFF; tx_bytes[1] = 8'h00;
    run_case("ff00", 2, 129 + 1024 + 4 * 128, -1, -1);

    // 0x0F with enable dropped at the start of bit 3.
    tx_bytes[0] = 8'h0F;
    run_case("drop_b3", 1, 129 + 3 * 128, -1, -1);

    // Look-ahead fetch killed by an enable pulse: underrun at byte end.
    tx_bytes[0] = 8'h3C;
    run_case("underrun", 1, -1, 149, 129 + 1024);
    bus.enable = 1'b1;
    step();
    check("fetch_clears_urun", 128'(bus.underrun),  128'd0);
    check("fetch_reenter_frm", 128'(bus.ssp_frame), 128'd1);
    reset = 1'b1;
    step();
    check_idle("rst_in_fetch");

    // Reset in the middle of SEND, while ssp_clk is high.
    do_reset();
    arm_q.push_back(8'hFF);
    bus.enable = 1'b1;
    for (int c = 0; c < 133; c++) step();
    check("midsend_act",  128'(bus.tx_active), 128'd1);
    check("midsend_sclk", 128'(bus.ssp_clk),   128'd1);
    reset = 1'b1;
    step();
    check_idle("rst_mid_send");
    reset = 1'b0;
    bus.enable = 1'b0;

    // Random byte streams, stopped somewhere in the last byte after bit 0.
    for (int r = 0; r < 3; r++) begin
      nb  = $urandom_range(1, 3);
      bt  = $urandom_range(1, 7);
      off = $urandom_range(0, 127);
      for (int i = 0; i < nb; i++) tx_bytes[i] = 8'($urandom);
      run_case($sformatf("rnd%0d", r), nb, 129 + 1024 * (nb - 1) + 128 * bt + off, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule : tb_hi_sim_bpsk_tx
`default_nettype wire
